// File: rtl/diferential_muxpga_pkg.sv
// Shared types and sizing helpers for the second-generation mux-FPGA fabric.
package diferential_muxpga_pkg;

   localparam int unsigned NIB_W = 4;

   typedef enum logic [1:0] {
      CMD_SHIFT = 2'd0,
      CMD_STEP  = 2'd1,
      CMD_RUN   = 2'd2,
      CMD_PEEK  = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      F_OR   = 3'd0,
      F_AND  = 3'd1,
      F_IN1  = 3'd2,
      F_IN2  = 3'd3,
      F_XOR  = 3'd4,
      F_ADD  = 3'd5,
      F_NOT  = 3'd6,
      F_HOLD = 3'd7
   } func_e;

   typedef enum logic [1:0] {
      SEL_N  = 2'd0,
      SEL_S  = 2'd1,
      SEL_W  = 2'd2,
      SEL_IN = 2'd3
   } sel_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Number of configurable cells (row 0 is the external input row).
   function automatic int unsigned ncells(input int unsigned rows, input int unsigned cols);
      return (rows - 1) * cols;
   endfunction

   // Config chain length in nibbles: one mux and one func nibble per cell.
   function automatic int unsigned chain_len(input int unsigned rows, input int unsigned cols);
      return 2 * ncells(rows, cols);
   endfunction

endpackage

// File: rtl/diferential_cell_v2.sv
// One B-bit logic cell: 8-function ALU feeding an enabled register.
module diferential_cell_v2
   import diferential_muxpga_pkg::*;
#(
   parameter int unsigned B = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [NIB_W-1:0] func,
   input  logic [B-1:0]     in1,
   input  logic [B-1:0]     in2,
   output logic [B-1:0]     q
);

   logic [B-1:0] f_out;
   logic         unused_rsvd;

   // Bit 3 of the func nibble is reserved.
   assign unused_rsvd = func[3];

   // Cell function; HOLD recirculates the current value.
   always_comb begin
      f_out = q;
      case (func_e'(func[2:0]))
         F_OR:   f_out = in1 | in2;
         F_AND:  f_out = in1 & in2;
         F_IN1:  f_out = in1;
         F_IN2:  f_out = in2;
         F_XOR:  f_out = in1 ^ in2;
         F_ADD:  f_out = in1 + in2;
         F_NOT:  f_out = ~in1;
         F_HOLD: f_out = q;
      endcase
   end

   // Cell register loads only when the fabric evaluates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= f_out;
      end
   end

endmodule

// File: rtl/diferential_muxpga_gen.sv
// Mux-FPGA fabric: config shift chain, cell grid with neighbour muxing,
// STEP/RUN evaluation control and registered cell readback.
module diferential_muxpga_gen
   import diferential_muxpga_pkg::*;
#(
   parameter int unsigned ROWS = 5,
   parameter int unsigned COLS = 3,
   parameter int unsigned B    = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     cmd,
   input  logic [B-1:0]   din,
   output logic [2*B-1:0] dout,
   output logic           busy
);

   localparam int unsigned NCELLS = ncells(ROWS, COLS);
   localparam int unsigned L      = chain_len(ROWS, COLS);
   localparam int unsigned PW     = $clog2(NCELLS);
   localparam int unsigned PAD    = 2 * B - NIB_W;

   logic [NIB_W-1:0] chain [L];
   logic [B-1:0]     q     [NCELLS];
   state_e           state, state_nxt;
   logic [B-1:0]     run_cnt;
   logic [PW-1:0]    peek_idx, peek_idx_nxt;
   logic             cell_en, shift_en, peek_en, run_start;

   // Neighbour select for one cell input.
   function automatic logic [B-1:0] pick(input logic [1:0] sel, input logic [B-1:0] n,
                                         input logic [B-1:0] s, input logic [B-1:0] w,
                                         input logic [B-1:0] i);
      logic [B-1:0] r;
      r = n;
      case (sel_e'(sel))
         SEL_N:  r = n;
         SEL_S:  r = s;
         SEL_W:  r = w;
         SEL_IN: r = i;
      endcase
      return r;
   endfunction

   // Next state and command decode; every cmd is ignored while running.
   always_comb begin
      state_nxt = state;
      cell_en   = 1'b0;
      shift_en  = 1'b0;
      peek_en   = 1'b0;
      run_start = 1'b0;
      case (state)
         ST_IDLE: begin
            case (cmd_e'(cmd))
               CMD_SHIFT: shift_en = 1'b1;
               CMD_STEP:  cell_en  = 1'b1;
               CMD_RUN: begin
                  run_start = 1'b1;
                  state_nxt = ST_RUN;
               end
               CMD_PEEK:  peek_en  = 1'b1;
            endcase
         end
         ST_RUN: begin
            cell_en = 1'b1;
            if (run_cnt == '0) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // State register; busy mirrors the RUN state as a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == ST_RUN);
      end
   end

   // Run counter: loaded on RUN, counts down to the final evaluation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt <= '0;
      end else if (run_start) begin
         run_cnt <= din;
      end else if (state == ST_RUN && run_cnt != '0) begin
         run_cnt <= run_cnt - B'(1);
      end
   end

   // Config shift chain, newest nibble at index 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(L); i++) chain[i] <= '0;
      end else if (shift_en) begin
         chain[0] <= din[NIB_W-1:0];
         for (int i = 1; i < int'(L); i++) chain[i] <= chain[i-1];
      end
   end

   // Peek index, clamped to the last cell.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peek_idx <= '0;
      end else if (peek_en) begin
         if (32'(din) >= NCELLS) peek_idx <= PW'(NCELLS - 1);
         else                    peek_idx <= PW'(din);
      end
   end

   // Companion readback index wraps to cell 0.
   assign peek_idx_nxt = (peek_idx == PW'(NCELLS - 1)) ? '0 : peek_idx + PW'(1);

   // Readback: chain tail during SHIFT, otherwise the peeked cell pair.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= '0;
      end else if (shift_en) begin
         dout <= {chain[L-1], {PAD{1'b0}}};
      end else begin
         dout <= {q[peek_idx], q[peek_idx_nxt]};
      end
   end

   // Cell grid; row 0 and the input-row select are both din.
   for (genvar r = 1; r < int'(ROWS); r++) begin : g_row
      for (genvar c = 0; c < int'(COLS); c++) begin : g_col
         localparam int unsigned K  = (r - 1) * COLS + c;
         localparam int unsigned RN = r - 1;
         localparam int unsigned RS = (r + 1) % ROWS;
         localparam int unsigned CW = (c + COLS - 1) % COLS;

         logic [B-1:0] north, south, west, in1, in2;

         if (RN == 0) begin : g_n_in
            assign north = din;
         end else begin : g_n_cell
            assign north = q[(RN - 1) * COLS + c];
         end

         if (RS == 0) begin : g_s_in
            assign south = din;
         end else begin : g_s_cell
            assign south = q[(RS - 1) * COLS + c];
         end

         assign west = q[(r - 1) * COLS + CW];
         assign in1  = pick(chain[2*K][1:0], north, south, west, din);
         assign in2  = pick(chain[2*K][3:2], north, south, west, din);

         diferential_cell_v2 #(.B(B)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (cell_en),
            .func  (chain[2*K+1]),
            .in1   (in1),
            .in2   (in2),
            .q     (q[K])
         );
      end
   end

endmodule

// File: doc/diferential_muxpga_gen.md
# diferential_muxpga_gen

Parametrised second-generation mux-FPGA fabric: a ROWS×COLS grid of B-bit logic cells configured through a nibble-wide shift chain. Row 0 is the external input row. Compared with the first generation, it adds XOR, ADD, NOT and HOLD cell functions, a multi-cycle RUN mode with a busy flag, and selectable readback of any cell. It sits directly behind the chip I/O wrapper, which maps pins onto cmd, din and dout.

## Interface
Parameters:
- ROWS, 5 — grid rows including input row 0; ≥2
- COLS, 3 — grid columns; ≥2
- B, 4 — cell data width; ≥4

Ports:
- clk  in  1  — single clock, rising edge
- reset  in  1  — asynchronous, active-high; clears all state
- cmd  in  2  — 0 SHIFT, 1 STEP, 2 RUN, 3 PEEK
- din  in  B  — config nibble (din[3:0]), run count, peek index and row-0 data
- dout  out  2B  — registered readback
- busy  out  1  — high while in RUN

## Operation
- NCELLS = (ROWS-1)·COLS. Cell k = (row-1)·COLS + col, for rows 1..ROWS-1.
- Config chain: L = 2·NCELLS nibbles.
  - SHIFT (not busy): chain[0] ← din[3:0], chain[i] ← chain[i-1]. Tail is chain[L-1].
  - Cell k takes its mux nibble from chain[2k] and its func nibble from chain[2k+1].
- Mux nibble: [1:0] selects in1, [3:2] selects in2.
  - 0 = north (row-1 mod ROWS)
  - 1 = south (row+1 mod ROWS)
  - 2 = west (col-1 mod COLS)
  - 3 = input row, column (row+col) mod COLS
- Row-0 "cells" are din, combinationally.
- Func nibble [2:0]: 0 OR, 1 AND, 2 in1, 3 in2, 4 XOR, 5 ADD (mod 2^B, carry dropped), 6 NOT in1, 7 HOLD. Bit 3 is reserved and ignored.
- A cell register loads f_out only when enabled; otherwise it holds.
- Enable = (IDLE and cmd==STEP) or state==RUN.
- FSM states IDLE and RUN:
  - IDLE, cmd==RUN: run_cnt ← din, go to RUN. Cells are not enabled on this edge.
  - RUN: cells enabled every edge. If run_cnt==0, go to IDLE; else run_cnt−1.
  - Total enabled edges = din+1.
- While in RUN, all cmd values are ignored: no shift, no peek update, no re-trigger.
- PEEK (not busy): peek_idx ← din. If din ≥ NCELLS, peek_idx ← NCELLS−1.
- dout register, updated every edge:
  - IDLE and cmd==SHIFT: dout ← {tail nibble, zeros}.
  - Otherwise: dout ← {q[peek_idx], q[(peek_idx+1) mod NCELLS]}.
- Reset values: all chain nibbles, cell registers, run_cnt, peek_idx and dout are 0. State is IDLE; busy is 0.

## Timing
- The STEP edge updates cells at that same edge. dout shows the result one edge later.
- The RUN command edge raises busy. busy stays high for exactly din+1 cycles, then drops on the edge performing the last enabled evaluation.
- A SHIFT issued in the cycle busy falls is accepted, because the FSM is IDLE by then.
- dout lags its source by one cycle. The first edge of PEEK loads peek_idx; dout reflects the new cell on the following edge.
- Asynchronous reset mid-RUN aborts immediately: busy=0, dout=0, and the config is lost.
- Release of reset is synchronised externally; this block does not resynchronise it.

## Structure
- diferential_muxpga_pkg holds:
  - cmd enum (CMD_SHIFT/STEP/RUN/PEEK)
  - func enum (F_OR … F_HOLD)
  - mux-select enum (SEL_N/S/W/IN)
  - state enum (ST_IDLE/ST_RUN)
  - the NCELLS and chain-length functions
- One sub-module: diferential_cell_v2 (B-bit register, 8-function ALU, enable). Neighbour muxing is generated inline in the top.

## Test plan
- Reset with the chain loaded: assert reset mid-pattern → dout=0, busy=0. Then 12 STEPs with func 0 leave every cell at 0.
- Shift readback: SHIFT L=24 nibbles 0x1..0x8 repeating → the next SHIFT shows the first nibble (0x1) in dout[7:4] one cycle later.
- Accumulator: cell(1,0) ADD, in1=north, in2=south; cell(2,0) func in1, in1=north; din=1. Issue 5 STEPs with peek_idx=0 → q(1,0) sequence 1, 1, 2, 2, 3; q(2,0) sequence 0, 1, 1, 2, 2.
- RUN/busy: cell(1,0) NOT in1, in1=north. RUN with din=2 → busy high 3 cycles; a SHIFT issued mid-run leaves the tail unchanged; final q(1,0)=0xD.
- PEEK clamp: PEEK din=15 (NCELLS=12) → dout = {q[11], q[0]}.
- Wrap muxing: cell(4,2), in1=south (row 0 = din), in2=west (cell(4,1)=0x0), func XOR; din=0xA; STEP → q(4,2)=0xA.
